// File: rtl/add_sum_acc_pkg.sv
// Shared types and sizing helpers for the sum accumulator.
// Optional averaging output is enabled by defining ADD_SUM_ACC_AVG_EN.
package add_sum_acc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam int unsigned SUM_W_DEF = 5;
    localparam int unsigned CNT_DEF   = 8;

    // Ceiling log2 for sizing parameters at elaboration time.
    function automatic int unsigned f_clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'(1) << i) < 64'(v)) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    localparam int unsigned ACC_W_DEF = SUM_W_DEF + f_clog2(CNT_DEF);
    localparam int unsigned CNT_W_DEF = f_clog2(CNT_DEF + 1);

endpackage

// File: rtl/add_acc_if.sv
// Signal bundle mirroring the add_sum_acc ports, used by the bench to drive the block.
// Carries out_avg only when ADD_SUM_ACC_AVG_EN is defined.
interface add_acc_if
    import add_sum_acc_pkg::*;
#(
    parameter int unsigned SUM_W = SUM_W_DEF,
    parameter int unsigned ACC_W = ACC_W_DEF,
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input logic clk
);
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [SUM_W-1:0] in_sum;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_acc;
    logic [CNT_W-1:0] out_cnt;
`ifdef ADD_SUM_ACC_AVG_EN
    logic [SUM_W-1:0] out_avg;
`endif
endinterface

// File: rtl/add_sum_acc.sv
// Accumulates a frame of CNT adder sums (or a flushed partial frame) and presents total + count.
// Define ADD_SUM_ACC_AVG_EN to add the rounded-average output out_avg.
module add_sum_acc
    import add_sum_acc_pkg::*;
#(
    parameter int unsigned SUM_W = SUM_W_DEF,
    parameter int unsigned CNT   = CNT_DEF,
    parameter int unsigned ACC_W = SUM_W + f_clog2(CNT),
    parameter int unsigned CNT_W = f_clog2(CNT + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [SUM_W-1:0] in_sum,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_acc,
`ifdef ADD_SUM_ACC_AVG_EN
    output logic [SUM_W-1:0] out_avg,
`endif
    output logic [CNT_W-1:0] out_cnt
);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [ACC_W-1:0] r_acc;
    logic [CNT_W-1:0] r_cnt;
    logic             r_out_valid;
    logic [ACC_W-1:0] r_out_acc;
    logic [CNT_W-1:0] r_out_cnt;

    logic             w_accept;
    logic             w_last;
    logic [ACC_W-1:0] w_acc_sum;
    logic [CNT_W-1:0] w_cnt_inc;
    logic [ACC_W-1:0] w_frame_acc;
    logic [CNT_W-1:0] w_frame_cnt;
    logic             w_enter_hold;

    assign in_ready  = (r_state != HOLD);
    assign w_accept  = in_valid && in_ready;
    assign w_acc_sum = r_acc + ACC_W'(in_sum);
    assign w_cnt_inc = r_cnt + CNT_W'(1);
    assign w_last    = (w_cnt_inc == CNT_W'(CNT));

    // Frame result includes a sum accepted on the closing edge.
    assign w_frame_acc  = w_accept ? w_acc_sum : r_acc;
    assign w_frame_cnt  = w_accept ? w_cnt_inc : r_cnt;
    assign w_enter_hold = (r_state != HOLD) && (w_state_nxt == HOLD);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                // A lone flush with nothing accumulated is ignored.
                if (w_accept) begin
                    w_state_nxt = (flush || w_last) ? HOLD : ACCUM;
                end
            end
            ACCUM: begin
                if ((w_accept && w_last) || flush) begin
                    w_state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc       <= '0;
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
            r_out_acc   <= '0;
            r_out_cnt   <= '0;
        end else begin
            if (r_state == HOLD) begin
                if (out_ready) begin
                    r_acc <= '0;
                    r_cnt <= '0;
                end
            end else if (w_accept) begin
                r_acc <= w_acc_sum;
                r_cnt <= w_cnt_inc;
            end
            if (w_enter_hold) begin
                r_out_acc <= w_frame_acc;
                r_out_cnt <= w_frame_cnt;
            end
            r_out_valid <= (w_state_nxt == HOLD);
        end
    end

    assign out_valid = r_out_valid;
    assign out_acc   = r_out_acc;
    assign out_cnt   = r_out_cnt;

`ifdef ADD_SUM_ACC_AVG_EN
    logic [SUM_W-1:0] r_out_avg;
    logic [ACC_W-1:0] w_avg_full;

    // Round-half-up divide by CNT; cannot overflow ACC_W since the max total is below CNT*2^SUM_W - CNT/2.
    assign w_avg_full = (w_frame_acc + ACC_W'(CNT / 2)) >> f_clog2(CNT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_avg <= '0;
        end else if (w_enter_hold) begin
            r_out_avg <= SUM_W'(w_avg_full);
        end
    end

    assign out_avg = r_out_avg;
`endif

endmodule

// File: tb/tb_add_sum_acc.sv
// Directed self-checking bench for add_sum_acc (default CNT=8, SUM_W=5).
// Also checks out_avg when built with ADD_SUM_ACC_AVG_EN.
module tb_add_sum_acc;
    import add_sum_acc_pkg::*;

    logic clk;
    int   n_checks;
    int   n_fail;

    add_acc_if ifc (.clk(clk));

    add_sum_acc dut (
        .clk       (clk),
        .rst       (ifc.rst),
        .in_valid  (ifc.in_valid),
        .in_ready  (ifc.in_ready),
        .in_sum    (ifc.in_sum),
        .flush     (ifc.flush),
        .out_valid (ifc.out_valid),
        .out_ready (ifc.out_ready),
        .out_acc   (ifc.out_acc),
`ifdef ADD_SUM_ACC_AVG_EN
        .out_avg   (ifc.out_avg),
`endif
        .out_cnt   (ifc.out_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        ifc.out_ready = 1'b1;
        tick();
        ifc.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        ifc.rst = 1'b1; ifc.in_valid = 1'b0; ifc.in_sum = '0; ifc.flush = 1'b0; ifc.out_ready = 1'b0;
        #2;
        n_checks++; if (ifc.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", ifc.in_ready); end
        n_checks++; if (ifc.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", ifc.out_valid); end
        n_checks++; if (ifc.out_acc !== 8'd0) begin n_fail++; $display("FAIL reset_out_acc: got %0d want 0", ifc.out_acc); end
        n_checks++; if (ifc.out_cnt !== 4'd0) begin n_fail++; $display("FAIL reset_out_cnt: got %0d want 0", ifc.out_cnt); end
        tick();
        ifc.rst = 1'b0;
        tick();
    endtask

    task automatic test_full_frame();
        ifc.in_valid = 1'b1; ifc.in_sum = 5'd30;
        repeat (7) tick();
        n_checks++; if (ifc.out_valid !== 1'b0) begin n_fail++; $display("FAIL full_early_valid: got %b want 0", ifc.out_valid); end
        tick();
        ifc.in_valid = 1'b0;
        n_checks++; if (ifc.out_valid !== 1'b1) begin n_fail++; $display("FAIL full_valid: got %b want 1", ifc.out_valid); end
        n_checks++; if (ifc.out_acc !== 8'd240) begin n_fail++; $display("FAIL full_acc: got %0d want 240", ifc.out_acc); end
        n_checks++; if (ifc.out_cnt !== 4'd8) begin n_fail++; $display("FAIL full_cnt: got %0d want 8", ifc.out_cnt); end
        n_checks++; if (ifc.in_ready !== 1'b0) begin n_fail++; $display("FAIL full_in_ready: got %b want 0", ifc.in_ready); end
`ifdef ADD_SUM_ACC_AVG_EN
        n_checks++; if (ifc.out_avg !== 5'd30) begin n_fail++; $display("FAIL full_avg: got %0d want 30", ifc.out_avg); end
`endif
        drain();
        n_checks++; if (ifc.out_valid !== 1'b0) begin n_fail++; $display("FAIL full_release_valid: got %b want 0", ifc.out_valid); end
        n_checks++; if (ifc.in_ready !== 1'b1) begin n_fail++; $display("FAIL full_release_ready: got %b want 1", ifc.in_ready); end
    endtask

    task automatic test_back_pressure();
        ifc.in_valid = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            ifc.in_sum = 5'(i);
            tick();
        end
        ifc.in_sum = 5'd20;
        for (int c = 0; c < 5; c++) begin
            n_checks++; if (ifc.out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid[%0d]: got %b want 1", c, ifc.out_valid); end
            n_checks++; if (ifc.out_acc !== 8'd36) begin n_fail++; $display("FAIL bp_acc[%0d]: got %0d want 36", c, ifc.out_acc); end
            n_checks++; if (ifc.out_cnt !== 4'd8) begin n_fail++; $display("FAIL bp_cnt[%0d]: got %0d want 8", c, ifc.out_cnt); end
            n_checks++; if (ifc.in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready[%0d]: got %b want 0", c, ifc.in_ready); end
            tick();
        end
        ifc.out_ready = 1'b1;
        tick();
        ifc.out_ready = 1'b0;
        n_checks++; if (ifc.out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_release_valid: got %b want 0", ifc.out_valid); end
        n_checks++; if (ifc.in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_ready: got %b want 1", ifc.in_ready); end
        tick();
        // Exactly one copy of the held 20 must have been accepted.
        ifc.in_valid = 1'b0; ifc.flush = 1'b1;
        tick();
        ifc.flush = 1'b0;
        n_checks++; if (ifc.out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_ninth_valid: got %b want 1", ifc.out_valid); end
        n_checks++; if (ifc.out_acc !== 8'd20) begin n_fail++; $display("FAIL bp_ninth_acc: got %0d want 20", ifc.out_acc); end
        n_checks++; if (ifc.out_cnt !== 4'd1) begin n_fail++; $display("FAIL bp_ninth_cnt: got %0d want 1", ifc.out_cnt); end
        drain();
    endtask

    task automatic test_early_flush();
        ifc.flush = 1'b1;
        tick();
        ifc.flush = 1'b0;
        n_checks++; if (ifc.out_valid !== 1'b0) begin n_fail++; $display("FAIL idle_flush_valid: got %b want 0", ifc.out_valid); end
        n_checks++; if (ifc.in_ready !== 1'b1) begin n_fail++; $display("FAIL idle_flush_ready: got %b want 1", ifc.in_ready); end
        ifc.in_valid = 1'b1; ifc.in_sum = 5'd7;
        tick();
        ifc.in_sum = 5'd9;
        tick();
        ifc.in_valid = 1'b0; ifc.flush = 1'b1;
        tick();
        ifc.flush = 1'b0;
        n_checks++; if (ifc.out_valid !== 1'b1) begin n_fail++; $display("FAIL flush_valid: got %b want 1", ifc.out_valid); end
        n_checks++; if (ifc.out_acc !== 8'd16) begin n_fail++; $display("FAIL flush_acc: got %0d want 16", ifc.out_acc); end
        n_checks++; if (ifc.out_cnt !== 4'd2) begin n_fail++; $display("FAIL flush_cnt: got %0d want 2", ifc.out_cnt); end
`ifdef ADD_SUM_ACC_AVG_EN
        n_checks++; if (ifc.out_avg !== 5'd2) begin n_fail++; $display("FAIL flush_avg: got %0d want 2", ifc.out_avg); end
`endif
        drain();
    endtask

    task automatic test_flush_with_accept();
        ifc.in_valid = 1'b1; ifc.in_sum = 5'd5;
        tick();
        ifc.in_sum = 5'd10; ifc.flush = 1'b1;
        tick();
        ifc.in_valid = 1'b0; ifc.flush = 1'b0;
        n_checks++; if (ifc.out_valid !== 1'b1) begin n_fail++; $display("FAIL flacc_valid: got %b want 1", ifc.out_valid); end
        n_checks++; if (ifc.out_acc !== 8'd15) begin n_fail++; $display("FAIL flacc_acc: got %0d want 15", ifc.out_acc); end
        n_checks++; if (ifc.out_cnt !== 4'd2) begin n_fail++; $display("FAIL flacc_cnt: got %0d want 2", ifc.out_cnt); end
        drain();
        // Flush together with the first sum of a frame closes a one-sample frame.
        ifc.in_valid = 1'b1; ifc.in_sum = 5'd6; ifc.flush = 1'b1;
        tick();
        ifc.in_valid = 1'b0; ifc.flush = 1'b0;
        n_checks++; if (ifc.out_valid !== 1'b1) begin n_fail++; $display("FAIL idle_flacc_valid: got %b want 1", ifc.out_valid); end
        n_checks++; if (ifc.out_acc !== 8'd6) begin n_fail++; $display("FAIL idle_flacc_acc: got %0d want 6", ifc.out_acc); end
        n_checks++; if (ifc.out_cnt !== 4'd1) begin n_fail++; $display("FAIL idle_flacc_cnt: got %0d want 1", ifc.out_cnt); end
        drain();
    endtask

    task automatic test_bubbles_max();
        for (int i = 0; i < 8; i++) begin
            ifc.in_valid = 1'b1; ifc.in_sum = 5'd31;
            tick();
            ifc.in_valid = 1'b0;
            if (i < 7) repeat ($urandom_range(0, 3)) tick();
        end
        n_checks++; if (ifc.out_valid !== 1'b1) begin n_fail++; $display("FAIL max_valid: got %b want 1", ifc.out_valid); end
        n_checks++; if (ifc.out_acc !== 8'd248) begin n_fail++; $display("FAIL max_acc: got %0d want 248", ifc.out_acc); end
        n_checks++; if (ifc.out_cnt !== 4'd8) begin n_fail++; $display("FAIL max_cnt: got %0d want 8", ifc.out_cnt); end
`ifdef ADD_SUM_ACC_AVG_EN
        n_checks++; if (ifc.out_avg !== 5'd31) begin n_fail++; $display("FAIL max_avg: got %0d want 31", ifc.out_avg); end
`endif
        drain();
    endtask

    task automatic test_reset_mid_frame();
        ifc.in_valid = 1'b1; ifc.in_sum = 5'd4;
        repeat (3) tick();
        ifc.in_valid = 1'b0;
        #3;
        ifc.rst = 1'b1;
        #1;
        n_checks++; if (ifc.in_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_in_ready: got %b want 1", ifc.in_ready); end
        n_checks++; if (ifc.out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_valid: got %b want 0", ifc.out_valid); end
        n_checks++; if (ifc.out_acc !== 8'd0) begin n_fail++; $display("FAIL midrst_acc: got %0d want 0", ifc.out_acc); end
        n_checks++; if (ifc.out_cnt !== 4'd0) begin n_fail++; $display("FAIL midrst_cnt: got %0d want 0", ifc.out_cnt); end
        #1;
        ifc.rst = 1'b0;
        tick();
        ifc.in_valid = 1'b1; ifc.in_sum = 5'd2;
        repeat (7) tick();
        n_checks++; if (ifc.out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_early_valid: got %b want 0", ifc.out_valid); end
        tick();
        ifc.in_valid = 1'b0;
        n_checks++; if (ifc.out_valid !== 1'b1) begin n_fail++; $display("FAIL midrst_next_valid: got %b want 1", ifc.out_valid); end
        n_checks++; if (ifc.out_acc !== 8'd16) begin n_fail++; $display("FAIL midrst_next_acc: got %0d want 16", ifc.out_acc); end
        n_checks++; if (ifc.out_cnt !== 4'd8) begin n_fail++; $display("FAIL midrst_next_cnt: got %0d want 8", ifc.out_cnt); end
        drain();
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_full_frame();
        test_back_pressure();
        test_early_flush();
        test_flush_with_accept();
        test_bubbles_max();
        test_reset_mid_frame();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
